// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory port controller.
package dmem_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [1:0] SizeByte    = 2'b00;
  localparam logic [1:0] SizeHalf    = 2'b01;
  localparam logic [1:0] SizeWord    = 2'b10;
  localparam logic [1:0] SizeWordAlt = 2'b11;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SizeByte: be = 4'b0001 << off;
      SizeHalf: be = off[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate_lanes(input logic [1:0] size,
                                                  input logic [31:0] data);
    logic [31:0] rep;
    case (size)
      SizeByte: rep = {4{data[7:0]}};
      SizeHalf: rep = {2{data[15:0]}};
      default:  rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed lane of a raw read word and sign/zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (size_i)
      SizeByte: data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SizeHalf: data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default:  data_o = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// MEM-stage to req/ack data-memory bridge with pipeline stall and misalignment detect.
// Optional bus timeout enabled by defining DMEM_TIMEOUT_EN.
module dmem_port_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] RegB,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  output logic [DATA_W-1:0] Memory_Read_Data,
  output logic              Mem_Stall,
  output logic              Misaligned,
  output logic              Bus_Error,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata
);

  if (DATA_W != 32 || TIMEOUT == 0) begin : g_param_check
    $error("dmem_port_ctrl: DATA_W must be 32 and TIMEOUT must be nonzero");
  end

  state_e            state_q, state_d;
  logic              dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        off_q, off_d, size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [DATA_W-1:0] load_data;
  logic              access, size_is_word, misaligned;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;
`endif

  // Lane/size info is latched at request time so extraction never depends on held inputs.
  dmem_load_align u_load_align (
    .rdata_i  (dm_rdata),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .data_o   (load_data)
  );

  assign access       = MemRead | MemWrite;
  assign size_is_word = (MemSize == SizeWord) || (MemSize == SizeWordAlt);
  assign misaligned   = ((MemSize == SizeHalf) && ALU_out[0]) ||
                        (size_is_word && (ALU_out[1:0] != 2'b00));

  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    rdata_d    = rdata_q;
    off_d      = off_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    Mem_Stall  = 1'b0;
    Misaligned = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d      = '0;
    bus_err_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (misaligned) begin
            Misaligned = 1'b1;
          end else begin
            Mem_Stall  = 1'b1;
            dm_req_d   = 1'b1;
            dm_we_d    = MemWrite;
            dm_addr_d  = {ALU_out[ADDR_W-1:2], 2'b00};
            dm_be_d    = byte_enables(MemSize, ALU_out[1:0]);
            dm_wdata_d = replicate_lanes(MemSize, RegB);
            off_d      = ALU_out[1:0];
            size_d     = MemSize;
            sgn_d      = MemSigned;
            state_d    = StBusy;
          end
        end
      end
      StBusy: begin
        Mem_Stall = 1'b1;
        if (dm_ack) begin
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
          rdata_d  = dm_we_q ? '0 : load_data;
          state_d  = StDone;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          dm_req_d  = 1'b0;
          dm_we_d   = 1'b0;
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_be_q    <= '0;
      dm_wdata_q <= '0;
      rdata_q    <= '0;
      off_q      <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
      rdata_q    <= rdata_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
`endif
    end
  end

  assign dm_req           = dm_req_q;
  assign dm_we            = dm_we_q;
  assign dm_addr          = dm_addr_q;
  assign dm_be            = dm_be_q;
  assign dm_wdata         = dm_wdata_q;
  assign Memory_Read_Data = rdata_q;
`ifdef DMEM_TIMEOUT_EN
  assign Bus_Error        = bus_err_q;
`else
  assign Bus_Error        = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl: transaction-level expectation model plus literal pins.
module tb_dmem_port_ctrl;

  logic        clk;
  logic        reset;
  logic        MemRead, MemWrite, MemSigned;
  logic [31:0] ALU_out, RegB;
  logic [1:0]  MemSize;
  logic [31:0] Memory_Read_Data;
  logic        Mem_Stall, Misaligned, Bus_Error;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;

  dmem_port_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .ALU_out          (ALU_out),
    .RegB             (RegB),
    .MemSize          (MemSize),
    .MemSigned        (MemSigned),
    .Memory_Read_Data (Memory_Read_Data),
    .Mem_Stall        (Mem_Stall),
    .Misaligned       (Misaligned),
    .Bus_Error        (Bus_Error),
    .dm_req           (dm_req),
    .dm_we            (dm_we),
    .dm_addr          (dm_addr),
    .dm_be            (dm_be),
    .dm_wdata         (dm_wdata),
    .dm_ack           (dm_ack),
    .dm_rdata         (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs for the current cycle, set by the stimulus tasks.
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_mis = 1'b0, exp_req = 1'b0, exp_berr = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_data = '0;
  logic [3:0]  exp_be = '0;

  int          stall_cnt = 0, mis_cnt = 0, req_cnt = 0, berr_cnt = 0;
  logic [3:0]  seen_be = '0;
  logic [31:0] seen_addr = '0, seen_wdata = '0;
  logic        seen_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    int n;
    n = nbytes(size);
    for (int k = 0; k < 4; k++) be[k] = (k >= int'(off)) && (k < int'(off) + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = nbytes(size);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [1:0] off,
                                             input logic [1:0] size, input logic sgn);
    logic [31:0] v;
    int n;
    n = nbytes(size);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = raw[8*(int'(off) + i) +: 8];
    if (sgn && n < 4 && v[8*n-1]) for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("Mem_Stall", 32'(Mem_Stall), 32'(exp_stall));
      check("Misaligned", 32'(Misaligned), 32'(exp_mis));
      check("dm_req", 32'(dm_req), 32'(exp_req));
      check("Bus_Error", 32'(Bus_Error), 32'(exp_berr));
      check("Memory_Read_Data", Memory_Read_Data, exp_data);
      if (exp_req) begin
        check("dm_we", 32'(dm_we), 32'(exp_we));
        check("dm_addr", dm_addr, exp_addr);
        check("dm_be", 32'(dm_be), 32'(exp_be));
        check("dm_wdata", dm_wdata, exp_wdata);
      end
      if (Mem_Stall) stall_cnt++;
      if (Misaligned) mis_cnt++;
      if (Bus_Error) berr_cnt++;
      if (dm_req) begin
        req_cnt++;
        seen_be    = dm_be;
        seen_addr  = dm_addr;
        seen_wdata = dm_wdata;
        seen_we    = dm_we;
      end
    end
  end

  task automatic set_idle();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    exp_stall = 1'b0;
    exp_mis   = 1'b0;
    exp_req   = 1'b0;
    exp_berr  = 1'b0;
  endtask

  // One MEM-stage access; ack arrives on BUSY cycle wait_n+1. Inputs stay up through DONE.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] regb, input logic [1:0] size, input logic sgn,
                           input int wait_n, input logic [31:0] raw);
    logic mis;
    mis       = (rd | wr) && ((int'(addr[1:0]) % nbytes(size)) != 0);
    MemRead   = rd;
    MemWrite  = wr;
    ALU_out   = addr;
    RegB      = regb;
    MemSize   = size;
    MemSigned = sgn;
    exp_mis   = mis;
    exp_stall = (rd | wr) && !mis;
    @(posedge clk); #1;
    if (!exp_stall) begin
      set_idle();
      return;
    end
    exp_req   = 1'b1;
    exp_we    = wr;
    exp_addr  = {addr[31:2], 2'b00};
    exp_be    = model_be(size, addr[1:0]);
    exp_wdata = model_wdata(size, regb);
    for (int i = 0; i <= wait_n; i++) begin
      dm_ack   = (i == wait_n);
      dm_rdata = (i == wait_n) ? raw : 32'hA5A5_5A5A;
      @(posedge clk); #1;
    end
    dm_ack    = 1'b0;
    dm_rdata  = 32'h0F0F_0F0F;
    exp_req   = 1'b0;
    exp_stall = 1'b0;
    exp_data  = wr ? 32'h0 : model_load(raw, addr[1:0], size, sgn);
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic idle_cycles(input int n, input logic ack);
    for (int i = 0; i < n; i++) begin
      dm_ack   = ack;
      dm_rdata = 32'h7777_7777;
      @(posedge clk); #1;
    end
    dm_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int s0, m0, r0, b0;

  initial begin
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemSigned = 1'b0;
    ALU_out = '0; RegB = '0; MemSize = 2'b10; dm_ack = 1'b0; dm_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_dm_req", 32'(dm_req), 32'h0);
    check("rst_dm_we", 32'(dm_we), 32'h0);
    check("rst_dm_be", 32'(dm_be), 32'h0);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_dm_wdata", dm_wdata, 32'h0);
    check("rst_read_data", Memory_Read_Data, 32'h0);
    check("rst_bus_error", 32'(Bus_Error), 32'h0);
    reset  = 1'b1;
    chk_en = 1'b1;
    idle_cycles(2, 1'b0);

    // Word load, ack on third BUSY cycle.
    s0 = stall_cnt;
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 2, 32'hDEAD_BEEF);
    check("ld_word_stall_cycles", 32'(stall_cnt - s0), 32'd4);
    check("ld_word_be", 32'(seen_be), 32'h0000_000F);
    check("ld_word_addr", seen_addr, 32'h100);
    check("ld_word_data", Memory_Read_Data, 32'hDEAD_BEEF);

    s0 = stall_cnt;
    do_access(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 0, 32'h80FF_0000);
    check("ld_sbyte_stall_cycles", 32'(stall_cnt - s0), 32'd2);
    check("ld_sbyte_be", 32'(seen_be), 32'h0000_0008);
    check("ld_sbyte_data", Memory_Read_Data, 32'hFFFF_FF80);
    do_access(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 1, 32'h80FF_0000);
    check("ld_ubyte_data", Memory_Read_Data, 32'h0000_0080);

    do_access(1'b0, 1'b1, 32'h206, 32'h1234_ABCD, 2'b01, 1'b0, 1, 32'h0);
    check("st_half_we", 32'(seen_we), 32'h1);
    check("st_half_be", 32'(seen_be), 32'h0000_000C);
    check("st_half_wdata", seen_wdata, 32'hABCD_ABCD);
    check("st_half_addr", seen_addr, 32'h204);
    check("st_half_data_zero", Memory_Read_Data, 32'h0);

    s0 = stall_cnt; m0 = mis_cnt; r0 = req_cnt;
    do_access(1'b1, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 0, 32'h0);
    idle_cycles(1, 1'b0);
    check("mis_word_pulses", 32'(mis_cnt - m0), 32'd1);
    check("mis_word_no_req", 32'(req_cnt - r0), 32'd0);
    check("mis_word_no_stall", 32'(stall_cnt - s0), 32'd0);
    m0 = mis_cnt; r0 = req_cnt;
    do_access(1'b1, 1'b0, 32'h101, 32'h0, 2'b01, 1'b1, 0, 32'h0);
    check("mis_half_pulses", 32'(mis_cnt - m0), 32'd1);
    check("mis_half_no_req", 32'(req_cnt - r0), 32'd0);

    do_access(1'b1, 1'b0, 32'h202, 32'h0, 2'b01, 1'b1, 3, 32'h8001_1234);
    check("ld_shalf_data", Memory_Read_Data, 32'hFFFF_8001);
    do_access(1'b0, 1'b1, 32'h101, 32'h0000_005A, 2'b00, 1'b0, 0, 32'h0);
    check("st_byte_be", 32'(seen_be), 32'h0000_0002);
    check("st_byte_wdata", seen_wdata, 32'h5A5A_5A5A);
    do_access(1'b1, 1'b1, 32'h208, 32'h1122_3344, 2'b10, 1'b0, 0, 32'h0);
    check("rw_write_wins", 32'(seen_we), 32'h1);

    // Stray acks outside BUSY must do nothing.
    r0 = req_cnt;
    idle_cycles(3, 1'b1);
    check("idle_ack_no_req", 32'(req_cnt - r0), 32'd0);

    do_access(1'b1, 1'b0, 32'h10C, 32'h0, 2'b11, 1'b1, 0, 32'hCAFE_F00D);
    check("ld_size11_data", Memory_Read_Data, 32'hCAFE_F00D);

`ifdef DMEM_TIMEOUT_EN
    s0 = stall_cnt; r0 = req_cnt; b0 = berr_cnt;
    MemRead = 1'b1; ALU_out = 32'h400; MemSize = 2'b10; MemSigned = 1'b0; RegB = '0;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h400; exp_be = 4'hF; exp_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    exp_req = 1'b0; exp_stall = 1'b0; exp_berr = 1'b1; exp_data = 32'h0;
    @(posedge clk); #1;
    set_idle();
    idle_cycles(1, 1'b0);
    check("to_stall_cycles", 32'(stall_cnt - s0), 32'd5);
    check("to_req_cycles", 32'(req_cnt - r0), 32'd4);
    check("to_bus_error_pulses", 32'(berr_cnt - b0), 32'd1);
    check("to_data_zero", Memory_Read_Data, 32'h0);
`endif

    // Reset in the middle of a transaction abandons it.
    b0 = berr_cnt;
    MemRead = 1'b1; ALU_out = 32'h300; MemSize = 2'b10; MemSigned = 1'b0; RegB = '0;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h300; exp_be = 4'hF; exp_wdata = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
    exp_req = 1'b0; exp_stall = 1'b0; exp_data = 32'h0;
    check("rst_busy_req_low", 32'(dm_req), 32'h0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    idle_cycles(2, 1'b0);
    check("rst_busy_ack_ignored", Memory_Read_Data, 32'h0);
    check("rst_busy_no_pulse", 32'(berr_cnt - b0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_ctrl.md
# dmem_port_ctrl

Sequential access controller sitting directly downstream of the MEM stage, between its control/address/data outputs and a variable-latency data-memory port. Converts one-cycle MemRead/MemWrite requests into a req/ack bus transaction with byte enables, stalls the pipeline until the access completes, and returns aligned, sign- or zero-extended load data to MEM/WB. Detects misaligned accesses and, optionally, bus timeouts.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 4 byte lanes)
- TIMEOUT, 255, max BUSY cycles without dm_ack (only with DMEM_TIMEOUT_EN)

- clk  in  1  clock
- reset  in  1  one clock; reset is synchronous and active-low
- MemRead  in  1  load request from EX/MEM register
- MemWrite  in  1  store request; wins if both asserted
- ALU_out  in  ADDR_W  byte address
- RegB  in  DATA_W  store data (low bits used for byte/half)
- MemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- MemSigned  in  1  1 = sign-extend load, 0 = zero-extend
- Memory_Read_Data  out  DATA_W  extended load data to MEM/WB
- Mem_Stall  out  1  freeze IF..MEM while high
- Misaligned  out  1  one-cycle exception pulse
- Bus_Error  out  1  one-cycle timeout pulse (0 without macro)
- dm_req, dm_we  out  1  bus request / write strobe
- dm_addr  out  ADDR_W  word-aligned address ({ALU_out[ADDR_W-1:2],2'b00})
- dm_be  out  4  byte enables
- dm_wdata  out  DATA_W  lane-replicated store data
- dm_ack  in  1  one-cycle completion; dm_rdata valid same cycle
- dm_rdata  in  DATA_W  raw word read data

## Operation
- FSM states IDLE, BUSY, DONE.
- IDLE: access = MemRead|MemWrite. Aligned access -> Mem_Stall=1 (combinational), register dm_req=1, dm_we, dm_addr, dm_be, dm_wdata; next BUSY. Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> no request, Misaligned=1 this cycle, Mem_Stall=0, stay IDLE.
- BUSY: Mem_Stall=1, bus outputs held. dm_ack=1 -> dm_req=0, capture extracted load data (stores capture 0), next DONE.
- DONE: Mem_Stall=0, Memory_Read_Data valid; pipeline advances this cycle; next IDLE. DONE never starts a new access.
- dm_be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) / 1100; word 1111. dm_wdata: byte replicated ×4, half ×2, word as-is.
- Load extract: lane selected by addr[1:0]; byte bit 7 / half bit 15 extended per MemSigned.
- dm_ack in IDLE or DONE ignored. Inputs assumed stable while Mem_Stall=1.

## Timing
- Reset (reset=0 at posedge): state IDLE, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, Memory_Read_Data=0, Misaligned=0, Bus_Error=0, timeout counter 0. Reset mid-BUSY abandons the transaction; no pulse.
- Latency: access seen cycle N, dm_req high from N+1, ack at N+1 earliest, data valid and stall low at N+2. Stall cycles = 2 + ack wait cycles.
- Memory_Read_Data holds until next capture or reset.

## Configuration
- DMEM_TIMEOUT_EN defined: counter increments each BUSY cycle without ack; reaching TIMEOUT -> dm_req=0, Memory_Read_Data=0, Bus_Error pulse in DONE cycle, next DONE. Counter clears on leaving BUSY.
- Undefined: BUSY waits indefinitely; Bus_Error tied 0; no counter logic.

## Structure
- Package dmem_pkg: state enum, MemSize encodings, byte-enable and lane-replication functions.
- Sub-module dmem_load_align: combinational lane select plus sign/zero extension.

## Test plan
- Word load addr 0x100, ack after 3 BUSY cycles, dm_rdata 0xDEADBEEF -> dm_be 1111, dm_addr 0x100, Memory_Read_Data 0xDEADBEEF, Mem_Stall high 4 cycles.
- Signed byte load addr 0x103, dm_rdata 0x80FF0000 -> dm_be 1000, result 0xFFFFFF80; unsigned -> 0x00000080.
- Half store addr 0x206, RegB 0x1234ABCD -> dm_we=1, dm_be 1100, dm_wdata 0xABCDABCD, dm_addr 0x204.
- Word load addr 0x102 -> Misaligned one cycle, dm_req never asserted, Mem_Stall 0.
- reset low during BUSY -> next cycle dm_req 0, IDLE, later ack ignored.
- DMEM_TIMEOUT_EN, TIMEOUT=4, no ack -> dm_req drops after 4 BUSY cycles, Bus_Error pulse, data 0.
